ce_pulse_checker: RTL
=====================

CE_PULSE_CHECKER -- requirements
Module: ce_pulse_checker

Interface
REQ-001 Parameter NCH, default 4: number of independent enable channels checked, 1..32.
REQ-002 Parameter MIN_LEN, default 16: minimum legal pulse length in clk cycles, >= 1.
REQ-003 Parameter MAX_LEN, default 16: maximum legal pulse length in clk cycles, >= MIN_LEN; elaboration error otherwise.
REQ-004 Parameter CNTW, default 8: error counter width, 1..16.
REQ-005 clk  input  1  single clock; all sampling and state changes on posedge clk.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 en  input  1  checker enable; low forces all channels to SKIP and suppresses errors.
REQ-008 ce  input  NCH  monitored enable lines, one bit per channel, sampled at posedge clk.
REQ-009 clr  input  1  synchronous clear of sticky_err and err_cnt.
REQ-010 short_err  output  NCH  one-cycle pulse per channel: pulse ended with length < MIN_LEN.
REQ-011 long_err  output  NCH  one-cycle pulse per channel: pulse exceeded MAX_LEN.
REQ-012 sticky_err  output  NCH  per-channel latched OR of short_err and long_err.
REQ-013 busy  output  NCH  per-channel high while the channel FSM is in HIGH.
REQ-014 err_cnt  output  CNTW  saturating total error count over all channels.

Function
REQ-015 Each channel SHALL run an independent FSM with states SKIP, IDLE, HIGH and a length counter of width $clog2(MAX_LEN+2), saturating at MAX_LEN+1.
REQ-016 SKIP: ce sampled 0 -> IDLE; ce sampled 1 -> stay; no errors raised.
REQ-017 IDLE: ce sampled 1 -> HIGH with length = 1; ce sampled 0 -> stay.
REQ-018 HIGH, ce sampled 1: length increments; if the new length would be MAX_LEN+1, long_err SHALL pulse and the FSM SHALL go to SKIP.
REQ-019 HIGH, ce sampled 0: if length < MIN_LEN, short_err SHALL pulse; FSM SHALL go to IDLE in either case.
REQ-020 Pulse of length L, MIN_LEN <= L <= MAX_LEN, SHALL raise no error.
REQ-021 All outputs SHALL be registered; short_err/long_err SHALL be high for exactly the one cycle following the edge that samples the violating ce value.
REQ-022 At most one error per pulse; a long pulse SHALL NOT also raise short_err at its falling edge.
REQ-023 A low gap of one cycle between pulses SHALL be sufficient to re-arm (HIGH -> IDLE -> HIGH).
REQ-024 en sampled 0: all FSMs -> SKIP, counters cleared, no error pulses that cycle; re-arming requires a low ce sample after en returns to 1.
REQ-025 sticky_err[i] SHALL set on any error of channel i and hold until clr or reset.
REQ-026 err_cnt SHALL add the number of error pulses raised on the same edge (0..2*NCH), saturating at 2^CNTW-1 and never wrapping.
REQ-027 clr together with new errors on the same edge: clear applies first; sticky_err = the new errors, err_cnt = their count.

Reset
REQ-028 rst_n sampled 0 SHALL force every FSM to SKIP, length counters to 0, and short_err, long_err, sticky_err, busy, err_cnt to 0, overriding en and clr.
REQ-029 Reset asserted mid-pulse SHALL abandon the pulse without an error; a ce held high across reset release SHALL NOT be checked.

Configuration
REQ-030 Macro CE_PULSE_CHECKER_ERRCNT_EN defined: err_cnt behaves per REQ-026/027.
REQ-031 Macro undefined: counter logic omitted, err_cnt tied to 0; port list unchanged; all other behaviour identical.

Verification (NCH=4, MIN_LEN=MAX_LEN=16, CNTW=8, macro defined)
REQ-032 ce[0] low 2 cycles, high exactly 16, low -> no error pulses, sticky_err=0, err_cnt=0, busy[0] high 16 cycles.
REQ-033 ce[1] high 8 cycles then low -> short_err[1] one cycle after the low sample, sticky_err=4'b0010, err_cnt=1.
REQ-034 ce[2] high 20 cycles -> long_err[2] once, after the 17th high sample; no short_err at fall; err_cnt=1.
REQ-035 ce[0] and ce[3] each high 5 cycles, falling on the same edge, with clr on that edge -> sticky_err=4'b1001, err_cnt=2.
REQ-036 ce[0] high across rst_n release, then 16-cycle pulse after a low -> no errors; rst_n low mid-pulse -> all outputs 0, no error.
REQ-037 300 consecutive 3-cycle pulses on ce[1] -> err_cnt=255 and holds; build without the macro -> err_cnt=0 throughout.

Source files
------------

// File: rtl/ce_pulse_checker.sv
// ce_pulse_checker: per-channel clock-enable pulse length checker with sticky flags.
// Define CE_PULSE_CHECKER_ERRCNT_EN to build the saturating err_cnt; otherwise err_cnt is tied to 0.
module ce_pulse_checker #(
    parameter int NCH     = 4,
    parameter int MIN_LEN = 16,
    parameter int MAX_LEN = 16,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NCH-1:0]  ce,
    input  logic            clr,
    output logic [NCH-1:0]  short_err,
    output logic [NCH-1:0]  long_err,
    output logic [NCH-1:0]  sticky_err,
    output logic [NCH-1:0]  busy,
    output logic [CNTW-1:0] err_cnt
);
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);
    localparam logic [LW-1:0] MINL = LW'(MIN_LEN);
    localparam logic [LW-1:0] ONE  = LW'(1);

    if (NCH < 1 || NCH > 32 || MIN_LEN < 1 || MAX_LEN < MIN_LEN || CNTW < 1 || CNTW > 16) begin : g_bad_params
        $error("ce_pulse_checker: illegal parameter combination");
    end

    typedef enum logic [1:0] {SKIP, IDLE, HIGH} state_t;

    state_t         st   [NCH];
    state_t         nst  [NCH];
    logic [LW-1:0]  len  [NCH];
    logic [LW-1:0]  nlen [NCH];
    logic [NCH-1:0] s_nxt, l_nxt, b_nxt;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            nst[i]   = st[i];
            nlen[i]  = len[i];
            s_nxt[i] = 1'b0;
            l_nxt[i] = 1'b0;
            if (!en) begin
                nst[i]  = SKIP;
                nlen[i] = '0;
            end else begin
                case (st[i])
                    SKIP: nst[i] = ce[i] ? SKIP : IDLE;
                    IDLE: if (ce[i]) begin
                        nst[i]  = HIGH;
                        nlen[i] = ONE;
                    end
                    HIGH: if (ce[i]) begin
                        // the sample that would make the length MAX_LEN+1 is the violation
                        if (len[i] >= MAXL) begin
                            l_nxt[i] = 1'b1;
                            nst[i]   = SKIP;
                            nlen[i]  = MAXL + ONE;
                        end else begin
                            nlen[i] = len[i] + ONE;
                        end
                    end else begin
                        s_nxt[i] = len[i] < MINL;
                        nst[i]   = IDLE;
                        nlen[i]  = '0;
                    end
                    default: nst[i] = SKIP;
                endcase
            end
            b_nxt[i] = nst[i] == HIGH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                st[i]  <= SKIP;
                len[i] <= '0;
            end
            short_err  <= '0;
            long_err   <= '0;
            sticky_err <= '0;
            busy       <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                st[i]  <= nst[i];
                len[i] <= nlen[i];
            end
            short_err  <= s_nxt;
            long_err   <= l_nxt;
            sticky_err <= (clr ? '0 : sticky_err) | s_nxt | l_nxt;
            busy       <= b_nxt;
        end
    end

`ifdef CE_PULSE_CHECKER_ERRCNT_EN
    localparam int CW = $clog2(2 * NCH + 1);
    localparam logic [16:0] CMAX = 17'((32'd1 << CNTW) - 1);

    logic [CW-1:0] errs;
    logic [16:0]   cnt_sum;

    always_comb begin
        errs = '0;
        for (int i = 0; i < NCH; i++)
            errs = errs + CW'(s_nxt[i]) + CW'(l_nxt[i]);
    end

    assign cnt_sum = (clr ? 17'd0 : 17'(err_cnt)) + 17'(errs);

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt <= '0;
        else
            err_cnt <= (cnt_sum > CMAX) ? '1 : cnt_sum[CNTW-1:0];
    end
`else
    assign err_cnt = '0;
`endif
endmodule
